// File: rtl/float_mult_seq_pkg.sv
// float_mult_seq_pkg: shared defaults, FSM/special-case encodings and operand classification
package float_mult_seq_pkg;
    localparam int EXP_W_D = 8;
    localparam int MAN_W_D = 23;
    typedef enum logic [1:0] {IDLE, MULT, NORM, ROUND} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} special_t;
    function automatic special_t classify(input logic za, ia, na, zb, ib, nb);
        return (na || nb || (ia && zb) || (ib && za)) ? SP_NAN :
               (ia || ib) ? SP_INF : (za || zb) ? SP_ZERO : SP_NONE;
    endfunction
endpackage

// File: rtl/float_mult_seq_mult.sv
// seq_mant_mult: shift-add significand multiplier, one multiplier bit per clock
module seq_mant_mult #(parameter int N = 24) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic           busy,
    output logic           last,
    output logic [2*N-1:0] product
);
    localparam int CW = $clog2(N);
    logic [2*N-1:0] mc;
    logic [N-1:0]   mp;
    logic [CW-1:0]  cnt;
    assign last = cnt == CW'(N-1);
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            product <= '0;
            mc      <= '0;
            mp      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (load) begin
            product <= '0;
            mc      <= {{N{1'b0}}, mcand};
            mp      <= mplier;
            cnt     <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            product <= product + (mp[0] ? mc : '0);
            mc      <= mc << 1;
            mp      <= mp >> 1;
            cnt     <= cnt + 1'b1;
            busy    <= !last;
        end
endmodule

// File: rtl/float_mult_seq.sv
// float_mult_seq: sequential FP multiplier with RNE rounding, special cases and fixed latency
module float_mult_seq import float_mult_seq_pkg::*; #(
    parameter int EXP_W = EXP_W_D,
    parameter int MAN_W = MAN_W_D
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int N  = MAN_W + 1;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'(2**(EXP_W-1) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'(2**EXP_W - 1);
    state_t                  state;
    special_t                kind;
    logic                    sgn, guard, sticky;
    logic signed [EW-1:0]    exp_r, er;
    logic [MAN_W-1:0]        frac, fa, fb, frac_n;
    logic [EXP_W-1:0]        ea, eb;
    logic [2*N-1:0]          prod;
    logic                    mult_busy, mult_last, guard_n, sticky_n, ovf, unf;
    logic [MAN_W:0]          fr;
    logic [EXP_W+MAN_W:0]    nan_v, inf_v, zero_v, res_n;
    assign {ea, fa} = a[EXP_W+MAN_W-1:0];
    assign {eb, fb} = b[EXP_W+MAN_W-1:0];
    seq_mant_mult #(.N(N)) u_mult (
        .clock(clock), .reset(reset), .load(state == IDLE && start),
        .mcand({1'b1, fa}), .mplier({1'b1, fb}),
        .busy(mult_busy), .last(mult_last), .product(prod)
    );
    // a set product MSB means the significand is in [2,4): take fields one bit higher
    assign frac_n   = prod[2*N-1] ? prod[2*MAN_W:MAN_W+1] : prod[2*MAN_W-1:MAN_W];
    assign guard_n  = prod[2*N-1] ? prod[MAN_W] : prod[MAN_W-1];
    assign sticky_n = |prod[MAN_W-2:0] | (prod[2*N-1] & prod[MAN_W-1]);
    assign fr     = {1'b0, frac} + (MAN_W+1)'(guard & (sticky | frac[0]));
    assign er     = exp_r + EW'(fr[MAN_W]);
    assign ovf    = er >= EMAX;
    assign unf    = er <= 0;
    assign nan_v  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    assign inf_v  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zero_v = {sgn, {(EXP_W+MAN_W){1'b0}}};
    assign res_n  = kind == SP_NAN ? nan_v : kind == SP_INF ? inf_v : kind == SP_ZERO ? zero_v :
                    ovf ? inf_v : unf ? zero_v : {sgn, er[EXP_W-1:0], fr[MAN_W-1:0]};
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state     <= IDLE;
            kind      <= SP_NONE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            sgn       <= 1'b0;
            exp_r     <= '0;
            frac      <= '0;
            guard     <= 1'b0;
            sticky    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= MULT;
                    busy      <= 1'b1;
                    overflow  <= 1'b0;
                    underflow <= 1'b0;
                    sgn       <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
                    exp_r     <= EW'(ea) + EW'(eb) - BIAS;
                    kind      <= classify(ea == '0, &ea && fa == '0, &ea && |fa,
                                          eb == '0, &eb && fb == '0, &eb && |fb);
                end
                MULT: if (mult_busy && mult_last) state <= NORM;
                NORM: begin
                    state  <= ROUND;
                    exp_r  <= exp_r + EW'(prod[2*N-1]);
                    frac   <= frac_n;
                    guard  <= guard_n;
                    sticky <= sticky_n;
                end
                ROUND: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    result    <= res_n;
                    overflow  <= kind == SP_NONE && ovf;
                    underflow <= kind == SP_NONE && !ovf && unf;
                end
            endcase
        end
endmodule
